// File: rtl/led_rate_sequencer_if.sv
// led_rate_sequencer_if: button/auto inputs and blinker rate/enable outputs of the front panel
interface led_rate_sequencer_if;
  logic       i_button;
  logic       i_auto;
  logic [1:0] o_rate_sel;
  logic       o_enable;
  logic       o_step;
  modport master (output i_button, i_auto, input o_rate_sel, o_enable, o_step);
  modport slave  (input i_button, i_auto, output o_rate_sel, o_enable, o_step);
endinterface

// File: rtl/led_rate_sequencer.sv
// led_rate_sequencer: debounced button and auto request driving blinker power, mode and rate select
module led_rate_sequencer #(
  parameter int         c_DEBOUNCE_CNT = 250,
  parameter int         c_HOLD_CNT     = 12500,
  parameter int         c_DWELL_CNT    = 25000,
  parameter logic [1:0] c_START_SEL    = 2'b00
) (
  input logic                 i_clock,
  input logic                 i_reset_n,
  led_rate_sequencer_if.slave bus
);
  localparam int DB_W = $clog2(c_DEBOUNCE_CNT);
  localparam int HOLD_W = $clog2(c_HOLD_CNT + 1);
  localparam int DW_W = $clog2(c_DWELL_CNT);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(c_DEBOUNCE_CNT - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(c_HOLD_CNT);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(c_HOLD_CNT - 1);
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(c_DWELL_CNT - 1);

  typedef enum logic [1:0] {OFF, ON_MANUAL, ON_AUTO} state_t;

  logic [1:0]        btn_s, auto_s;
  logic              db, db_flip, long_p, short_p;
  logic [DB_W-1:0]   db_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [DW_W-1:0]   dwell, dwell_n;
  logic [1:0]        rate_sel, sel_n;
  logic              enable, step;
  state_t            state, state_n;

  assign db_flip = (btn_s[1] != db) && (db_cnt == DB_LAST);

  // press events are registered, so the FSM reacts one edge after detection
  always_ff @(posedge i_clock or negedge i_reset_n)
    if (!i_reset_n) begin
      btn_s    <= '0;
      auto_s   <= '0;
      db       <= 1'b0;
      db_cnt   <= '0;
      hold_cnt <= '0;
      long_p   <= 1'b0;
      short_p  <= 1'b0;
    end else begin
      btn_s    <= {btn_s[0], bus.i_button};
      auto_s   <= {auto_s[0], bus.i_auto};
      db       <= db ^ db_flip;
      db_cnt   <= (btn_s[1] == db || db_flip) ? '0 : db_cnt + 1'b1;
      hold_cnt <= !db ? '0 : (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + 1'b1;
      long_p   <= db && hold_cnt == HOLD_LAST;
      short_p  <= db && db_flip && hold_cnt < HOLD_LAST;
    end

  // priority: long press, short press, auto level, dwell expiry
  always_comb begin
    state_n = state;
    sel_n   = rate_sel;
    dwell_n = '0;
    if (state != OFF && long_p) begin
      state_n = OFF;
      sel_n   = c_START_SEL;
    end else
      case (state)
        OFF:
          if (short_p) state_n = auto_s[1] ? ON_AUTO : ON_MANUAL;
        ON_MANUAL:
          if (short_p) sel_n = rate_sel + 1'b1;
          else if (auto_s[1]) state_n = ON_AUTO;
        ON_AUTO:
          if (short_p || !auto_s[1]) state_n = ON_MANUAL;
          else if (dwell == DWELL_LAST) sel_n = rate_sel + 1'b1;
          else dwell_n = dwell + 1'b1;
        default: state_n = OFF;
      endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n)
    if (!i_reset_n) begin
      state    <= OFF;
      rate_sel <= c_START_SEL;
      dwell    <= '0;
      enable   <= 1'b0;
      step     <= 1'b0;
    end else begin
      state    <= state_n;
      rate_sel <= sel_n;
      dwell    <= dwell_n;
      enable   <= state_n != OFF;
      step     <= sel_n != rate_sel;
    end

  assign bus.o_rate_sel = rate_sel;
  assign bus.o_enable   = enable;
  assign bus.o_step     = step;
endmodule

// File: doc/led_rate_sequencer.md
# led_rate_sequencer

Front-panel controller for the LED blinker: debounces a raw push-button, runs a power/mode state machine and drives the blinker's 2-bit rate select and enable. It replaces the static rate switches with short-press stepping, long-press power-off and a timed auto-cycle mode. Outputs connect directly to the blinker's rate-select and enable inputs.

## Interface
- c_DEBOUNCE_CNT, 250: cycles the synchronized button must differ from the debounced state before the debounced state flips (≥2)
- c_HOLD_CNT, 12500: debounced-high cycles that constitute a long press (> c_DEBOUNCE_CNT)
- c_DWELL_CNT, 25000: cycles spent on each rate in AUTO (≥2)
- c_START_SEL, 2'b00: rate select loaded at reset and on entering OFF
- i_clock  in  1  single clock; all logic on its rising edge
- i_reset_n  in  1  reset, asynchronous assert, active-low
- i_button  in  1  raw push-button, asynchronous, active-high
- i_auto  in  1  auto-cycle request, asynchronous level
- o_rate_sel  out  2  rate select to blinker (00 fastest … 11 slowest)
- o_enable  out  1  blinker enable
- o_step  out  1  one-cycle pulse in the cycle o_rate_sel takes a new value

## Operation
- Reset: state OFF, o_rate_sel = c_START_SEL, o_enable = 0, o_step = 0; synchronizers, debounced state, and all counters cleared. Asserting reset mid-operation gives the same result immediately.
- i_button and i_auto each pass through a 2-FF synchronizer.
- Debounce: the counter increments while the synchronized button differs from the debounced state and clears to 0 when they match. When it reaches c_DEBOUNCE_CNT-1 and still differs, the debounced state toggles and the counter clears.
- Hold counter: counts cycles with the debounced state high, saturating at c_HOLD_CNT, and clears when the debounced state is low.
  - Long press: one event in the cycle the hold counter reaches c_HOLD_CNT-1.
  - Short press: debounced falling edge with no long press during that hold.
  - The release that follows a long press produces no event.
- States:
  - OFF: o_enable = 0; i_auto ignored. A short press moves to ON_MANUAL if synced i_auto = 0, otherwise to ON_AUTO. o_rate_sel is unchanged (already c_START_SEL), so there is no o_step pulse.
  - ON_MANUAL: o_enable = 1. A short press increments o_rate_sel modulo 4 (11 → 00) and pulses o_step. Synced i_auto = 1 moves to ON_AUTO.
  - ON_AUTO: o_enable = 1. The dwell counter counts 0..c_DWELL_CNT-1; at terminal count o_rate_sel increments modulo 4, o_step pulses, and the counter clears. A short press or synced i_auto = 0 moves to ON_MANUAL with o_rate_sel unchanged.
  - Any ON state: a long press moves to OFF. o_rate_sel is reloaded with c_START_SEL, and o_step pulses only if the value changed.
- Dwell counter clears on entry to ON_AUTO and on every o_rate_sel change.
- Simultaneous events, priority: long press > short press > i_auto change > dwell expiry. Example: a short press coinciding with dwell expiry in ON_AUTO goes to ON_MANUAL with no increment.

## Timing
- All outputs are registered.
- Button to event: a raw edge held stable reaches the debounced state after 2 (sync) + c_DEBOUNCE_CNT cycles.
- Event to outputs: state, o_rate_sel, o_enable and o_step update on the clock edge after the edge on which the event is detected (1-cycle latency).
- Long press: OFF is reached c_HOLD_CNT cycles after the debounced rise, plus 1.
- Auto mode: o_rate_sel changes every c_DWELL_CNT cycles exactly. o_step is high for exactly 1 cycle per change.
- i_auto: synced i_auto affects state 3 cycles after the raw change.
- Bounce: bounces shorter than c_DEBOUNCE_CNT cycles produce no event.

## Test plan
Bench parameters: c_DEBOUNCE_CNT=4, c_HOLD_CNT=20, c_DWELL_CNT=10, c_START_SEL=00.
- Reset check: drive i_reset_n low mid-operation in ON_AUTO with sel=10 → outputs 00/0/0 immediately (asynchronous); after release, OFF with no activity.
- Power on and step: press 8 cycles then release (short press) → o_enable=1, sel=00. Then 4 more short presses → sel 01, 10, 11, 00, one o_step pulse each.
- Bounce rejection: toggle i_button every 2 cycles for 30 cycles, then hold low → no event, outputs unchanged.
- Long press: in ON_MANUAL with sel=10, hold 40 cycles → OFF, o_enable=0, sel=00 with one o_step pulse. Release → no further change.
- Auto cycling: ON with i_auto=1 → sel advances every 10 cycles: 00, 01, 10, 11, 00 (wrap). Drop i_auto → ON_MANUAL and sel frozen.
- Collision: in ON_AUTO, time a short-press detection to the dwell terminal cycle → ON_MANUAL, sel not incremented, no o_step pulse.
